drive_change_logger: RTL and testbench
======================================

Name: drive_change_logger

Overview:
- Downstream consumer of a module's driven outputs: one scalar plus one 2-bit vector, concatenated into in_data.
- Once armed, samples in_data every cycle and records each value change with a sequence tag.
- Changes are buffered in a small show-ahead FIFO and drained over a valid/ready interface.
- Lets benches confirm that procedurally driven outputs (reg-type ports) change only when intended.

Parameters:
- WIDTH, 3, sampled bus width (bit 0 = scalar output, bits 2:1 = vector output).
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of change sequence tag.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- arm  input  1  start capture (pulse or level).
- disarm  input  1  stop capture.
- in_data  input  WIDTH  observed output bus.
- out_valid  output  1  FIFO head holds an entry.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  WIDTH  head value.
- out_tag  output  CNT_W  head sequence number.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: a change was dropped.
- active  output  1  high in BASE or RUN.

Behaviour:
- Reset (rst_n==0 at posedge): state=IDLE; FIFO emptied; tag counter, prev_q, overflow, level all 0; out_valid=0; out_data and out_tag read as 0.
- FSM:
  - IDLE: no capture. arm && !disarm -> BASE; on that edge clear overflow and the tag counter. FIFO contents are preserved.
  - BASE: prev_q <= in_data; no push. Next state RUN, or IDLE if disarm.
  - RUN: each posedge prev_q <= in_data. If in_data != prev_q, a change is detected. disarm -> IDLE; the change sampled on that same edge is still detected.
  - arm and disarm both high: disarm wins in every state. arm in BASE or RUN is ignored.
- Change handling:
  - Every detected change increments the tag counter, which wraps mod 2^CNT_W.
  - The pushed entry carries the pre-increment tag, so the first change after arm has tag 0.
  - Dropped changes still consume a tag, so the consumer sees the gap.
- Push/pop rules:
  - Pop occurs when out_valid && out_ready.
  - Push occurs when a change is detected and (level<DEPTH, or a pop happens on the same edge).
  - Change detected while full with no pop: entry dropped, overflow <= 1, which holds until the next IDLE->BASE transition or reset.
  - Push and pop on the same edge: level unchanged.
- Latency:
  - A change present before posedge k appears at the head (out_valid=1, if the FIFO was empty) immediately after posedge k. One cycle, registered.
  - Head outputs come straight from storage; out_ready does not combinationally affect out_data or out_tag.
- Empty/full:
  - out_valid = (level!=0).
  - out_ready while empty has no effect.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Reset mid-operation: synchronous reset overrides everything on that edge, including push and pop. The FIFO is empty on the following cycle.
- in_data is assumed synchronous to clk. No X-handling: X on in_data is a bench error.

Decomposition:
- Package drive_change_logger_pkg holds:
  - state_t enum {IDLE, BASE, RUN} (2-bit);
  - localparam defaults for WIDTH, DEPTH, CNT_W;
  - entry struct {tag, data}.
- Sub-module dcl_fifo:
  - parameterised synchronous show-ahead FIFO with push, pop, full, empty and level;
  - same clk/rst_n convention;
  - holds {tag,data} entries.
- Top module contains the FSM, prev_q, change detect, tag counter and overflow.

Test Plan:
- Reset, then arm; hold in_data=3'b000 for 2 cycles, then 3'b101, 3'b101, 3'b011 with out_ready=1 -> two entries in order: (data 3'b101, tag 0) then (data 3'b011, tag 1); overflow=0.
- DEPTH=4, out_ready=0, six distinct changes -> level=4; overflow=1 after the 5th; drained tags 0,1,2,3; next accepted change after re-arm has tag 0.
- Full FIFO, change with out_ready=1 on the same edge -> push accepted, level stays 4, overflow stays 0.
- arm and disarm high together in IDLE -> stays IDLE, active=0, no pushes for changes that follow. disarm in RUN on a change edge -> that change is logged and active drops the next cycle.
- CNT_W=2, seven changes drained continuously -> tags 0,1,2,3,0,1,2 (wrap).
- rst_n=0 for one cycle with level=3 mid-drain -> next cycle level=0, out_valid=0, state IDLE, overflow=0.

Source files
------------

// File: rtl/drive_change_logger_pkg.sv
// Shared types and default sizing for the drive change logger.
// The FIFO entry pairs a change sequence tag with the sampled bus value.
package drive_change_logger_pkg;

   localparam int DCL_WIDTH = 3;
   localparam int DCL_DEPTH = 4;
   localparam int DCL_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BASE = 2'd1,
      RUN  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DCL_CNT_W-1:0] tag;
      logic [DCL_WIDTH-1:0] data;
   } entry_t;

endpackage

// File: rtl/drive_change_logger_if.sv
// Valid/ready drain port carrying logged changes (value plus sequence tag).
interface drive_change_logger_if #(
   parameter int WIDTH = 3,
   parameter int CNT_W = 8
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] out_tag;

   modport master (output out_valid, output out_data, output out_tag, input out_ready);
   modport slave  (input out_valid, input out_data, input out_tag, output out_ready);
endinterface

// File: rtl/dcl_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible whenever not empty
// and reads as zero when empty.
module dcl_fifo #(
   parameter int E_W   = 11,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [E_W-1:0]         din,
   output logic [E_W-1:0]         dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic [E_W-1:0] mem_q [DEPTH];
   logic [E_W-1:0] mem_d [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]  level_q, level_d;
   logic           do_push_s, do_pop_s;

   assign empty     = (level_q == {LW{1'b0}});
   assign full      = (level_q == DEPTH_L);
   assign level     = level_q;
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);
   assign dout      = empty ? {E_W{1'b0}} : mem_q[rd_ptr_q];

   // Next pointer, occupancy and storage contents.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Control state; reset wins over any push or pop on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         level_q  <= {LW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: it is only read while the occupancy is non-zero.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: rtl/drive_change_logger.sv
// Arms on request, samples the observed bus every cycle and logs each value
// change with a sequence tag into a drainable FIFO.
module drive_change_logger
   import drive_change_logger_pkg::*;
#(
   parameter int WIDTH = DCL_WIDTH,
   parameter int DEPTH = DCL_DEPTH,
   parameter int CNT_W = DCL_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   arm,
   input  logic                   disarm,
   input  logic [WIDTH-1:0]       in_data,
   drive_change_logger_if.master  out_if,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   active
);
   localparam int E_W = CNT_W + WIDTH;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [CNT_W-1:0] tag_q, tag_d;
   logic             ovf_q, ovf_d;
   logic             change_s, push_s, pop_s;
   logic             fifo_full_s, fifo_empty_s;
   logic [E_W-1:0]   fifo_dout_s;

   assign pop_s            = !fifo_empty_s && out_if.out_ready;
   assign out_if.out_valid = !fifo_empty_s;
   assign out_if.out_tag   = fifo_dout_s[E_W-1:WIDTH];
   assign out_if.out_data  = fifo_dout_s[WIDTH-1:0];
   assign overflow         = ovf_q;
   assign active           = (state_q != IDLE);

   // Capture FSM, change detection, tag counter and sticky overflow.
   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      tag_d    = tag_q;
      ovf_d    = ovf_q;
      change_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (arm && !disarm) begin
               state_d = BASE;
               tag_d   = {CNT_W{1'b0}};
               ovf_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         BASE: begin
            prev_d  = in_data;
            state_d = disarm ? IDLE : RUN;
         end
         RUN: begin
            prev_d   = in_data;
            change_s = (in_data != prev_q);
            state_d  = disarm ? IDLE : RUN;
         end
         default: state_d = IDLE;
      endcase
      // A slot frees up on the same edge when the head is popped.
      push_s = change_s && (!fifo_full_s || pop_s);
      if (change_s) begin
         tag_d = tag_q + CNT_W'(1);
         if (!push_s) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_q;
         end
      end else begin
         tag_d = tag_d;
      end
   end

   // Register bank for the control path.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prev_q  <= {WIDTH{1'b0}};
         tag_q   <= {CNT_W{1'b0}};
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         tag_q   <= tag_d;
         ovf_q   <= ovf_d;
      end
   end

   dcl_fifo #(
      .E_W   (E_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .din   ({tag_q, in_data}),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (level)
   );

endmodule

// File: tb/tb_drive_change_logger.sv
// Self-checking bench: two loggers (8-bit and 2-bit tags) share stimulus and
// are compared with directed constants and a queue-based reference model.
module tb_drive_change_logger;

   logic       clk = 1'b0;
   logic       rst_n, arm, disarm, out_ready;
   logic [2:0] in_data;
   logic [2:0] level0, level1;
   logic       ovf0, ovf1, act0, act1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int         tag;
      logic [2:0] data;
   } ent_t;

   ent_t       mq[$];
   int         m_tag;
   logic [2:0] m_prev;
   bit         m_base, m_run, m_ovf;

   always #5 clk = ~clk;

   drive_change_logger_if #(.WIDTH(3), .CNT_W(8)) if0 ();
   drive_change_logger_if #(.WIDTH(3), .CNT_W(2)) if1 ();

   assign if0.out_ready = out_ready;
   assign if1.out_ready = out_ready;

   drive_change_logger #(.WIDTH(3), .DEPTH(4), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .in_data(in_data),
      .out_if(if0), .level(level0), .overflow(ovf0), .active(act0)
   );

   drive_change_logger #(.WIDTH(3), .DEPTH(4), .CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .in_data(in_data),
      .out_if(if1), .level(level1), .overflow(ovf1), .active(act1)
   );

   // Reference model: one clock edge of the logger's observable behaviour.
   function automatic void model_edge(input logic a, input logic d, input logic [2:0] din,
                                      input logic rdy, input logic rn);
      bit pop, change;
      ent_t e;
      if (!rn) begin
         mq.delete();
         m_tag = 0; m_prev = 3'b000; m_base = 0; m_run = 0; m_ovf = 0;
         return;
      end
      pop    = (mq.size() != 0) && rdy;
      change = m_run && (din != m_prev);
      if (m_run || m_base) m_prev = din;
      if (pop) void'(mq.pop_front());
      if (change) begin
         if (mq.size() < 4) begin
            e.tag = m_tag; e.data = din;
            mq.push_back(e);
         end else begin
            m_ovf = 1;
         end
         m_tag = m_tag + 1;
      end
      if (!m_base && !m_run) begin
         if (a && !d) begin
            m_base = 1; m_tag = 0; m_ovf = 0;
         end
      end else if (d) begin
         m_base = 0; m_run = 0;
      end else if (m_base) begin
         m_base = 0; m_run = 1;
      end
   endfunction

   task automatic step(input logic a, input logic d, input logic [2:0] din,
                       input logic rdy, input logic rn = 1'b1);
      arm = a; disarm = d; in_data = din; out_ready = rdy; rst_n = rn;
      model_edge(a, d, din, rdy, rn);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      n_checks++; if (level0 !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level0); end
      n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", if0.out_valid); end
      n_checks++; if (if0.out_data !== 3'b000) begin n_fail++; $display("FAIL reset_data got %b exp 000", if0.out_data); end
      n_checks++; if (if0.out_tag !== 8'd0) begin n_fail++; $display("FAIL reset_tag got %0d exp 0", if0.out_tag); end
      n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf0); end
      n_checks++; if (act0 !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b exp 0", act0); end
      n_checks++; if (level1 !== 3'd0) begin n_fail++; $display("FAIL reset_level1 got %0d exp 0", level1); end
   endtask

   task automatic test_basic();
      step(1'b1, 1'b0, 3'b000, 1'b1);
      n_checks++; if (act0 !== 1'b1) begin n_fail++; $display("FAIL basic_active got %b exp 1", act0); end
      step(1'b0, 1'b0, 3'b000, 1'b1);
      step(1'b0, 1'b0, 3'b000, 1'b1);
      n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_nochange_valid got %b exp 0", if0.out_valid); end
      step(1'b0, 1'b0, 3'b101, 1'b1);
      n_checks++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_first_valid got %b exp 1", if0.out_valid); end
      n_checks++; if (if0.out_data !== 3'b101) begin n_fail++; $display("FAIL basic_first_data got %b exp 101", if0.out_data); end
      n_checks++; if (if0.out_tag !== 8'd0) begin n_fail++; $display("FAIL basic_first_tag got %0d exp 0", if0.out_tag); end
      step(1'b0, 1'b0, 3'b101, 1'b1);
      n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %b exp 0", if0.out_valid); end
      step(1'b0, 1'b0, 3'b011, 1'b1);
      n_checks++; if (if0.out_data !== 3'b011) begin n_fail++; $display("FAIL basic_second_data got %b exp 011", if0.out_data); end
      n_checks++; if (if0.out_tag !== 8'd1) begin n_fail++; $display("FAIL basic_second_tag got %0d exp 1", if0.out_tag); end
      n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b exp 0", ovf0); end
      step(1'b0, 1'b1, 3'b011, 1'b1);
      n_checks++; if (act0 !== 1'b0) begin n_fail++; $display("FAIL basic_disarm_active got %b exp 0", act0); end
   endtask

   task automatic test_overflow();
      step(1'b1, 1'b0, 3'd0, 1'b0);
      step(1'b0, 1'b0, 3'd0, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 1'b0, 3'(i), 1'b0);
         if (i == 4) begin
            n_checks++; if (level0 !== 3'd4) begin n_fail++; $display("FAIL ovf_fill_level got %0d exp 4", level0); end
            n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", ovf0); end
         end
         if (i >= 5) begin
            n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL ovf_set change %0d got %b exp 1", i, ovf0); end
            n_checks++; if (level0 !== 3'd4) begin n_fail++; $display("FAIL ovf_level change %0d got %0d exp 4", i, level0); end
         end
      end
      step(1'b0, 1'b1, 3'd6, 1'b0);
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (if0.out_tag !== 8'(k)) begin n_fail++; $display("FAIL ovf_drain_tag got %0d exp %0d", if0.out_tag, k); end
         n_checks++; if (if0.out_data !== 3'(k + 1)) begin n_fail++; $display("FAIL ovf_drain_data got %0d exp %0d", if0.out_data, k + 1); end
         step(1'b0, 1'b0, 3'd6, 1'b1);
      end
      n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b exp 0", if0.out_valid); end
      n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", ovf0); end
      step(1'b1, 1'b0, 3'd0, 1'b0);
      n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL ovf_rearm_clear got %b exp 0", ovf0); end
      step(1'b0, 1'b0, 3'd0, 1'b0);
      step(1'b0, 1'b0, 3'd5, 1'b0);
      n_checks++; if (if0.out_tag !== 8'd0) begin n_fail++; $display("FAIL ovf_rearm_tag got %0d exp 0", if0.out_tag); end
      n_checks++; if (level0 !== 3'd1) begin n_fail++; $display("FAIL ovf_rearm_level got %0d exp 1", level0); end
      step(1'b0, 1'b1, 3'd5, 1'b1);
   endtask

   task automatic test_full_pop();
      step(1'b1, 1'b0, 3'd0, 1'b0);
      step(1'b0, 1'b0, 3'd0, 1'b0);
      for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 3'(i), 1'b0);
      n_checks++; if (level0 !== 3'd4) begin n_fail++; $display("FAIL fullpop_pre_level got %0d exp 4", level0); end
      step(1'b0, 1'b0, 3'd5, 1'b1);
      n_checks++; if (level0 !== 3'd4) begin n_fail++; $display("FAIL fullpop_level got %0d exp 4", level0); end
      n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf got %b exp 0", ovf0); end
      n_checks++; if (if0.out_tag !== 8'd1) begin n_fail++; $display("FAIL fullpop_head_tag got %0d exp 1", if0.out_tag); end
      step(1'b0, 1'b1, 3'd5, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'd5, 1'b1);
      n_checks++; if (level0 !== 3'd0) begin n_fail++; $display("FAIL fullpop_drained got %0d exp 0", level0); end
   endtask

   task automatic test_arm_disarm();
      step(1'b1, 1'b1, 3'd0, 1'b0);
      n_checks++; if (act0 !== 1'b0) begin n_fail++; $display("FAIL both_active got %b exp 0", act0); end
      step(1'b0, 1'b0, 3'd3, 1'b0);
      step(1'b0, 1'b0, 3'd4, 1'b0);
      n_checks++; if (level0 !== 3'd0) begin n_fail++; $display("FAIL both_no_push got %0d exp 0", level0); end
      step(1'b1, 1'b0, 3'd4, 1'b0);
      step(1'b0, 1'b0, 3'd4, 1'b0);
      step(1'b1, 1'b0, 3'd4, 1'b0);
      n_checks++; if (act0 !== 1'b1) begin n_fail++; $display("FAIL run_arm_ignored got %b exp 1", act0); end
      step(1'b0, 1'b1, 3'd2, 1'b0);
      n_checks++; if (level0 !== 3'd1) begin n_fail++; $display("FAIL disarm_change_level got %0d exp 1", level0); end
      n_checks++; if (if0.out_data !== 3'd2) begin n_fail++; $display("FAIL disarm_change_data got %0d exp 2", if0.out_data); end
      n_checks++; if (if0.out_tag !== 8'd0) begin n_fail++; $display("FAIL disarm_change_tag got %0d exp 0", if0.out_tag); end
      n_checks++; if (act0 !== 1'b0) begin n_fail++; $display("FAIL disarm_active got %b exp 0", act0); end
      step(1'b0, 1'b0, 3'd2, 1'b1);
   endtask

   task automatic test_wrap();
      step(1'b1, 1'b0, 3'd0, 1'b1);
      step(1'b0, 1'b0, 3'd0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0, 3'(i + 1), 1'b1);
         n_checks++; if (if1.out_tag !== 2'(i % 4)) begin n_fail++; $display("FAIL wrap_tag2 got %0d exp %0d", if1.out_tag, i % 4); end
         n_checks++; if (if0.out_tag !== 8'(i)) begin n_fail++; $display("FAIL wrap_tag8 got %0d exp %0d", if0.out_tag, i); end
         n_checks++; if (level1 !== 3'd1) begin n_fail++; $display("FAIL wrap_level got %0d exp 1", level1); end
      end
      step(1'b0, 1'b1, 3'd7, 1'b1);
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b0, 3'd0, 1'b0);
      step(1'b0, 1'b0, 3'd0, 1'b0);
      for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, 3'(i), 1'b0);
      n_checks++; if (level0 !== 3'd3) begin n_fail++; $display("FAIL rstmid_pre_level got %0d exp 3", level0); end
      step(1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
      n_checks++; if (level0 !== 3'd0) begin n_fail++; $display("FAIL rstmid_level got %0d exp 0", level0); end
      n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", if0.out_valid); end
      n_checks++; if (act0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_active got %b exp 0", act0); end
      n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf got %b exp 0", ovf0); end
      step(1'b0, 1'b0, 3'd6, 1'b0);
      n_checks++; if (level0 !== 3'd0) begin n_fail++; $display("FAIL rstmid_idle_level got %0d exp 0", level0); end
   endtask

   task automatic test_random();
      logic       a, d, rdy, rn;
      logic [2:0] din;
      logic [2:0] exp_data;
      int         exp_tag;
      din = in_data;
      for (int i = 0; i < 600; i++) begin
         a   = ($urandom_range(0, 7) == 0);
         d   = ($urandom_range(0, 15) == 0);
         rn  = ($urandom_range(0, 149) != 0);
         rdy = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 2) != 0) din = 3'($urandom_range(0, 7));
         step(a, d, din, rdy, rn);
         exp_data = (mq.size() != 0) ? mq[0].data : 3'b000;
         exp_tag  = (mq.size() != 0) ? mq[0].tag : 0;
         n_checks++; if (level0 !== 3'(mq.size())) begin n_fail++; $display("FAIL rand_level cyc %0d got %0d exp %0d", i, level0, mq.size()); end
         n_checks++; if (if0.out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_valid cyc %0d got %b", i, if0.out_valid); end
         n_checks++; if (if0.out_data !== exp_data) begin n_fail++; $display("FAIL rand_data cyc %0d got %0d exp %0d", i, if0.out_data, exp_data); end
         n_checks++; if (if0.out_tag !== 8'(exp_tag % 256)) begin n_fail++; $display("FAIL rand_tag8 cyc %0d got %0d exp %0d", i, if0.out_tag, exp_tag % 256); end
         n_checks++; if (if1.out_tag !== 2'(exp_tag % 4)) begin n_fail++; $display("FAIL rand_tag2 cyc %0d got %0d exp %0d", i, if1.out_tag, exp_tag % 4); end
         n_checks++; if (ovf0 !== m_ovf) begin n_fail++; $display("FAIL rand_ovf cyc %0d got %b exp %b", i, ovf0, m_ovf); end
         n_checks++; if (act0 !== (m_base || m_run)) begin n_fail++; $display("FAIL rand_active cyc %0d got %b", i, act0); end
         n_checks++; if (ovf1 !== ovf0 || act1 !== act0 || level1 !== level0) begin n_fail++; $display("FAIL rand_pair cyc %0d got %b%b%0d vs %b%b%0d", i, ovf1, act1, level1, ovf0, act0, level0); end
      end
   endtask

   initial begin
      rst_n = 1'b0; arm = 1'b0; disarm = 1'b0; in_data = 3'b000; out_ready = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_overflow();
      test_full_pop();
      test_arm_disarm();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
